// File: rtl/bp_fe_mem_pipe_if.sv
// Front-end memory pipe bus: command channel in, icache tag/data exchange,
// and response channel out. The slave side is the pipe, the master side is
// whatever issues fetch/fill/fence commands and consumes responses.
interface bp_fe_mem_pipe_if #(
  parameter int vtag_width_p  = 27,
  parameter int ptag_width_p  = 28,
  parameter int instr_width_p = 32,
  parameter int fetch_width_p = 2
);
  localparam int data_width_lp = fetch_width_p * instr_width_p;

  // Command channel
  logic                     cmd_v_i;
  logic [1:0]               cmd_op_i;
  logic [vtag_width_p-1:0]  cmd_vtag_i;
  logic [ptag_width_p-1:0]  cmd_ptag_i;
  logic [1:0]               cmd_attr_i;
  logic                     cmd_ready_o;

  // Icache exchange
  logic [ptag_width_p-1:0]  cache_ptag_o;
  logic                     cache_ptag_v_o;
  logic [data_width_lp-1:0] cache_data_i;
  logic                     cache_data_v_i;

  // Response channel
  logic                     resp_v_o;
  logic                     resp_ready_i;
  logic [data_width_lp-1:0] resp_data_o;
  logic [3:0]               resp_fault_o;

  modport slave (
    input  cmd_v_i, cmd_op_i, cmd_vtag_i, cmd_ptag_i, cmd_attr_i,
    output cmd_ready_o,
    output cache_ptag_o, cache_ptag_v_o,
    input  cache_data_i, cache_data_v_i,
    output resp_v_o, resp_data_o, resp_fault_o,
    input  resp_ready_i
  );

  modport master (
    output cmd_v_i, cmd_op_i, cmd_vtag_i, cmd_ptag_i, cmd_attr_i,
    input  cmd_ready_o,
    input  cache_ptag_o, cache_ptag_v_o,
    output cache_data_i, cache_data_v_i,
    input  resp_v_o, resp_data_o, resp_fault_o,
    output resp_ready_i
  );
endinterface

// File: rtl/bp_fe_mem_pipe.sv
// Front-end memory pipe: fully-associative ITLB lookup in the accept cycle,
// one registered stage (S2) that talks to the icache, and a 2-entry response
// FIFO. Fetch acceptance is throttled so the FIFO can never overflow.
// Optional ITLB hit/miss counters are built when BP_FE_MEM_PIPE_PERF_EN is
// defined; otherwise the counter outputs are tied to zero.
module bp_fe_mem_pipe #(
  parameter int vtag_width_p  = 27,
  parameter int ptag_width_p  = 28,
  parameter int tlb_els_p     = 8,
  parameter int instr_width_p = 32,
  parameter int fetch_width_p = 2,
  parameter logic [ptag_width_p-1:0] dram_base_ptag_p = 28'h0080000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        translation_en_i,
  input  logic [1:0]  priv_i,
  input  logic        poison_i,
  output logic [31:0] perf_hit_cnt_o,
  output logic [31:0] perf_miss_cnt_o,
  bp_fe_mem_pipe_if.slave bus
);

  localparam int data_width_lp = fetch_width_p * instr_width_p;
  localparam int idx_width_lp  = $clog2(tlb_els_p);
  localparam logic [1:0] priv_u_lp = 2'd0;
  localparam logic [1:0] priv_s_lp = 2'd1;

  typedef enum logic [1:0] {
    op_fetch = 2'd0,
    op_fill  = 2'd1,
    op_fence = 2'd2,
    op_rsvd  = 2'd3
  } cmd_op_e;

  typedef struct packed {
    logic [ptag_width_p-1:0] ptag;
    logic                    miss;
    logic                    pf;
    logic                    af;
    logic                    trans;
  } s2_payload_t;

  // ITLB state
  logic [tlb_els_p-1:0]    tlb_v_r;
  logic [vtag_width_p-1:0] tlb_vtag_r [tlb_els_p];
  logic [ptag_width_p-1:0] tlb_ptag_r [tlb_els_p];
  logic [1:0]              tlb_attr_r [tlb_els_p];
  logic [idx_width_lp-1:0] victim_r;

  // S2 and FIFO state
  logic                     s2_v_r;
  s2_payload_t              s2_r;
  logic [data_width_lp-1:0] fifo_data_r  [2];
  logic [3:0]               fifo_fault_r [2];
  logic                     fifo_wptr_r, fifo_rptr_r;
  logic [1:0]               fifo_cnt_r;

  cmd_op_e op;
  logic    cmd_ready, cmd_fire, fetch_fire, fill_fire, fence_fire;
  assign op = cmd_op_e'(bus.cmd_op_i);

  // Readiness depends on the op presented; only fetches need FIFO room.
  // NOTE: every always_comb assigns defaults first so no path leaves a latch.
  always_comb begin
    cmd_ready = 1'b0;
    case (op)
      op_fetch:          cmd_ready = (fifo_cnt_r + {1'b0, s2_v_r}) < 2'd2;
      op_fill, op_fence: cmd_ready = 1'b1;
      default:           cmd_ready = 1'b0;
    endcase
  end

  assign bus.cmd_ready_o = cmd_ready & ~reset_i;
  assign cmd_fire   = bus.cmd_v_i & bus.cmd_ready_o;
  assign fetch_fire = cmd_fire & (op == op_fetch);
  assign fill_fire  = cmd_fire & (op == op_fill);
  assign fence_fire = cmd_fire & (op == op_fence);

  logic                    lkp_hit, lkp_pf, lkp_af;
  logic [ptag_width_p-1:0] lkp_ptag;
  logic [1:0]              lkp_attr;

  // Associative lookup and fault classification in the accept cycle.
  always_comb begin
    lkp_hit  = 1'b0;
    lkp_ptag = '0;
    lkp_attr = '0;
    for (int i = 0; i < tlb_els_p; i++) begin
      if (tlb_v_r[i] && (tlb_vtag_r[i] == bus.cmd_vtag_i)) begin
        lkp_hit  = 1'b1;
        lkp_ptag = tlb_ptag_r[i];
        lkp_attr = tlb_attr_r[i];
      end
    end
    if (!translation_en_i) begin
      lkp_hit  = 1'b1;
      lkp_ptag = ptag_width_p'(bus.cmd_vtag_i);
      lkp_attr = '0;
    end
    // attr is {u, x}; machine mode only faults on a non-executable page
    lkp_pf = lkp_hit & translation_en_i &
             (~lkp_attr[0] | ((priv_i == priv_s_lp) & lkp_attr[1]) |
                             ((priv_i == priv_u_lp) & ~lkp_attr[1]));
    lkp_af = lkp_hit & ~lkp_pf & (lkp_ptag < dram_base_ptag_p);
  end

  logic                    fill_match, fill_free;
  logic [idx_width_lp-1:0] fill_match_idx, fill_free_idx, fill_idx;

  // Fill slot choice: existing match, else lowest invalid, else victim.
  always_comb begin
    fill_match     = 1'b0;
    fill_free      = 1'b0;
    fill_match_idx = '0;
    fill_free_idx  = '0;
    for (int i = tlb_els_p - 1; i >= 0; i--) begin
      if (tlb_v_r[i] && (tlb_vtag_r[i] == bus.cmd_vtag_i)) begin
        fill_match     = 1'b1;
        fill_match_idx = idx_width_lp'(i);
      end
      if (!tlb_v_r[i]) begin
        fill_free     = 1'b1;
        fill_free_idx = idx_width_lp'(i);
      end
    end
    fill_idx = fill_match ? fill_match_idx : (fill_free ? fill_free_idx : victim_r);
  end

  // ITLB valid bits and round-robin victim pointer.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tlb_v_r  <= '0;
      victim_r <= '0;
    end else if (fence_fire) begin
      tlb_v_r  <= '0;
      victim_r <= '0;
    end else if (fill_fire) begin
      tlb_v_r[fill_idx] <= 1'b1;
      if (!fill_match && !fill_free) victim_r <= victim_r + idx_width_lp'(1);
    end
  end

  // ITLB entry contents.
  // NOTE: storage arrays are not reset; their valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (fill_fire) begin
      tlb_vtag_r[fill_idx] <= bus.cmd_vtag_i;
      tlb_ptag_r[fill_idx] <= bus.cmd_ptag_i;
      tlb_attr_r[fill_idx] <= bus.cmd_attr_i;
    end
  end

  // S2 valid: a fetch poisoned in its accept cycle never enters S2.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) s2_v_r <= 1'b0;
    else         s2_v_r <= fetch_fire & ~poison_i;
  end

  // S2 payload captured with the accepted fetch.
  always_ff @(posedge clk_i) begin
    if (fetch_fire) s2_r <= '{ptag: lkp_ptag, miss: ~lkp_hit, pf: lkp_pf,
                              af: lkp_af, trans: translation_en_i};
  end

  logic                     s2_early_fault, s2_cm, push, pop;
  logic [3:0]               s2_fault;
  logic [data_width_lp-1:0] s2_data;

  assign s2_early_fault     = s2_r.miss | s2_r.pf | s2_r.af;
  assign s2_cm              = ~s2_early_fault & ~bus.cache_data_v_i;
  assign s2_fault           = {s2_r.miss, s2_r.pf, s2_r.af, s2_cm};
  assign s2_data            = (|s2_fault) ? '0 : bus.cache_data_i;
  assign bus.cache_ptag_o   = s2_r.ptag;
  assign bus.cache_ptag_v_o = s2_v_r & ~s2_early_fault & ~poison_i;
  assign push               = s2_v_r & ~poison_i;
  assign pop                = bus.resp_v_o & bus.resp_ready_i;

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fifo_wptr_r <= 1'b0;
      fifo_rptr_r <= 1'b0;
      fifo_cnt_r  <= '0;
    end else begin
      if (push) fifo_wptr_r <= ~fifo_wptr_r;
      if (pop)  fifo_rptr_r <= ~fifo_rptr_r;
      case ({push, pop})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: ;
      endcase
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_r[fifo_wptr_r]  <= s2_data;
      fifo_fault_r[fifo_wptr_r] <= s2_fault;
    end
  end

  assign bus.resp_v_o     = (fifo_cnt_r != 2'd0);
  assign bus.resp_data_o  = fifo_data_r[fifo_rptr_r];
  assign bus.resp_fault_o = fifo_fault_r[fifo_rptr_r];

`ifdef BP_FE_MEM_PIPE_PERF_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;

  // Saturating ITLB hit/miss counters for unpoisoned translated fetches.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else if (push && s2_r.trans) begin
      if (s2_r.miss) begin
        if (miss_cnt_r != '1) miss_cnt_r <= miss_cnt_r + 32'd1;
      end else begin
        if (hit_cnt_r != '1) hit_cnt_r <= hit_cnt_r + 32'd1;
      end
    end
  end

  assign perf_hit_cnt_o  = hit_cnt_r;
  assign perf_miss_cnt_o = miss_cnt_r;
`else
  logic unused_trans;
  assign unused_trans    = s2_r.trans;
  assign perf_hit_cnt_o  = '0;
  assign perf_miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_fe_mem_pipe.sv
// Self-checking bench for bp_fe_mem_pipe: directed scenarios followed by
// randomized traffic, all compared every cycle against a transaction-level
// model (TLB table, pending S2 transaction, response queue).
module tb_bp_fe_mem_pipe;
  localparam int vw = 27;
  localparam int pw = 28;
  localparam int dw = 64;
  localparam int tlb_els = 8;
  localparam logic [pw-1:0] dram_base = 28'h0080000;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        translation_en_i;
  logic [1:0]  priv_i;
  logic        poison_i;
  logic [31:0] perf_hit_cnt_o, perf_miss_cnt_o;

  bp_fe_mem_pipe_if #(.vtag_width_p(vw), .ptag_width_p(pw),
                      .instr_width_p(32), .fetch_width_p(2)) bus ();

  bp_fe_mem_pipe #(.vtag_width_p(vw), .ptag_width_p(pw), .tlb_els_p(tlb_els),
                   .instr_width_p(32), .fetch_width_p(2),
                   .dram_base_ptag_p(dram_base)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .translation_en_i(translation_en_i),
    .priv_i          (priv_i),
    .poison_i        (poison_i),
    .perf_hit_cnt_o  (perf_hit_cnt_o),
    .perf_miss_cnt_o (perf_miss_cnt_o),
    .bus             (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit              v;
    logic [vw-1:0]   vtag;
    logic [pw-1:0]   ptag;
    logic [1:0]      attr;
  } tlb_ent_t;

  typedef struct {
    logic [dw-1:0] data;
    logic [3:0]    fault;
  } resp_t;

  tlb_ent_t      m_tlb [tlb_els];
  int            m_victim;
  resp_t         m_q [$];
  bit            p_v, p_miss, p_pf, p_af, p_trans;
  logic [pw-1:0] p_ptag;
  int            m_hit_cnt, m_miss_cnt;

  // stimulus for the current cycle
  bit            s_v, s_trans, s_poison, s_cdv, s_rready;
  logic [1:0]    s_op, s_attr, s_priv;
  logic [vw-1:0] s_vtag;
  logic [pw-1:0] s_ptag;
  logic [dw-1:0] s_cdata;

  // observations from the latest cycle
  bit            last_acc, last_fire, obs_cpv, obs_rv, obs_ready;
  logic [3:0]    last_fault;
  logic [dw-1:0] last_data;

  task automatic model_fill(input logic [vw-1:0] vtag, input logic [pw-1:0] ptag,
                            input logic [1:0] attr);
    int idx = -1;
    for (int i = 0; i < tlb_els; i++)
      if (m_tlb[i].v && m_tlb[i].vtag == vtag) idx = i;
    if (idx < 0)
      for (int i = 0; i < tlb_els; i++)
        if (idx < 0 && !m_tlb[i].v) idx = i;
    if (idx < 0) begin
      idx = m_victim;
      m_victim = (m_victim + 1) % tlb_els;
    end
    m_tlb[idx] = '{v: 1'b1, vtag: vtag, ptag: ptag, attr: attr};
  endtask

  task automatic model_fence();
    for (int i = 0; i < tlb_els; i++) m_tlb[i].v = 1'b0;
    m_victim = 0;
  endtask

  // One clock cycle: drive, sample mid-cycle, compare, advance model.
  task automatic step();
    bit exp_ready, exp_cpv, hit, u, x;
    logic [pw-1:0] ptag;
    resp_t r;
    @(negedge clk_i);
    bus.cmd_v_i = s_v;  bus.cmd_op_i = s_op;  bus.cmd_vtag_i = s_vtag;
    bus.cmd_ptag_i = s_ptag;  bus.cmd_attr_i = s_attr;
    bus.cache_data_i = s_cdata;  bus.cache_data_v_i = s_cdv;
    bus.resp_ready_i = s_rready;
    translation_en_i = s_trans;  priv_i = s_priv;  poison_i = s_poison;
    #1;
    case (s_op)
      2'd0:    exp_ready = (m_q.size() + int'(p_v)) < 2;
      2'd1,
      2'd2:    exp_ready = 1'b1;
      default: exp_ready = 1'b0;
    endcase
    check("cmd_ready", bus.cmd_ready_o, exp_ready);
    check("resp_v", bus.resp_v_o, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("resp_data", bus.resp_data_o, m_q[0].data);
      check("resp_fault", bus.resp_fault_o, m_q[0].fault);
    end
    exp_cpv = p_v && !(p_miss || p_pf || p_af) && !s_poison;
    check("cache_ptag_v", bus.cache_ptag_v_o, exp_cpv);
    if (exp_cpv) check("cache_ptag", bus.cache_ptag_o, p_ptag);
`ifdef BP_FE_MEM_PIPE_PERF_EN
    check("perf_hit", perf_hit_cnt_o, m_hit_cnt);
    check("perf_miss", perf_miss_cnt_o, m_miss_cnt);
`else
    check("perf_hit", perf_hit_cnt_o, 0);
    check("perf_miss", perf_miss_cnt_o, 0);
`endif
    obs_cpv   = bus.cache_ptag_v_o;
    obs_rv    = bus.resp_v_o;
    obs_ready = bus.cmd_ready_o;
    last_fire = 1'b0;

    // model advance for the coming rising edge
    if (m_q.size() != 0 && s_rready) begin
      last_fire  = 1'b1;
      last_fault = bus.resp_fault_o;
      last_data  = bus.resp_data_o;
      void'(m_q.pop_front());
    end
    if (p_v && !s_poison) begin
      r.fault = {p_miss, p_pf, p_af, !(p_miss || p_pf || p_af) && !s_cdv};
      r.data  = (r.fault != 0) ? '0 : s_cdata;
      m_q.push_back(r);
      if (p_trans) begin
        if (p_miss) m_miss_cnt++;
        else        m_hit_cnt++;
      end
    end
    last_acc = s_v && exp_ready;
    p_v = last_acc && s_op == 2'd0 && !s_poison;
    if (last_acc && s_op == 2'd0) begin
      hit = 0; ptag = '0; u = 0; x = 0;
      if (!s_trans) begin
        hit = 1; ptag = pw'(s_vtag);
      end else begin
        for (int i = 0; i < tlb_els; i++)
          if (m_tlb[i].v && m_tlb[i].vtag == s_vtag) begin
            hit = 1; ptag = m_tlb[i].ptag; u = m_tlb[i].attr[1]; x = m_tlb[i].attr[0];
          end
      end
      p_trans = s_trans;
      p_ptag  = ptag;
      p_miss  = !hit;
      p_pf    = hit && s_trans && (!x || (s_priv == 2'd1 && u) || (s_priv == 2'd0 && !u));
      p_af    = hit && !p_pf && (ptag < dram_base);
    end
    if (last_acc && s_op == 2'd1) model_fill(s_vtag, s_ptag, s_attr);
    if (last_acc && s_op == 2'd2) model_fence();
  endtask

  task automatic send(input logic [1:0] op, input logic [vw-1:0] vtag,
                      input logic [pw-1:0] ptag, input logic [1:0] attr);
    s_v = 1; s_op = op; s_vtag = vtag; s_ptag = ptag; s_attr = attr;
    for (int k = 0; k < 20; k++) begin
      step();
      if (last_acc) break;
    end
    check("send_accept", last_acc, 1);
    s_v = 0;
  endtask

  task automatic wait_resp(input string tag, input logic [3:0] exp_fault, output int lat);
    bit seen = 0;
    lat = -1;
    s_rready = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_fire) begin
        check(tag, last_fault, exp_fault);
        seen = 1; lat = k;
        break;
      end
    end
    check({tag, "_seen"}, seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc, cpv_seen, rv_seen;
    logic [dw-1:0] d036;

    m_victim = 0; m_hit_cnt = 0; m_miss_cnt = 0; p_v = 0;
    for (int i = 0; i < tlb_els; i++) m_tlb[i] = '{v: 1'b0, vtag: '0, ptag: '0, attr: '0};
    s_v = 0; s_op = 2'd1; s_vtag = '0; s_ptag = '0; s_attr = '0; s_trans = 1;
    s_priv = 2'd1; s_poison = 0; s_cdata = '0; s_cdv = 1; s_rready = 1;

    // reset with a command presented: nothing may be accepted or emitted
    reset_i = 1'b1;
    bus.cmd_v_i = 1; bus.cmd_op_i = 2'd1; bus.cmd_vtag_i = '0; bus.cmd_ptag_i = '0;
    bus.cmd_attr_i = '0; bus.cache_data_i = '0; bus.cache_data_v_i = 1;
    bus.resp_ready_i = 1; translation_en_i = 1; priv_i = 2'd1; poison_i = 0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_cmd_ready", bus.cmd_ready_o, 0);
    check("rst_resp_v", bus.resp_v_o, 0);
    check("rst_cache_ptag_v", bus.cache_ptag_v_o, 0);
    @(posedge clk_i);
    #2 reset_i = 1'b0;

    // first cycle after reset: fill 0x10 -> 0x80010, {u=0,x=1}
    send(2'd1, 27'h10, 28'h0080010, 2'b01);
    check("first_cycle_accept", last_acc, 1);

    // supervisor fetch hit, cache hit: response two cycles later, clean data
    d036 = 64'h1234_5678_9abc_def0;
    s_cdata = d036; s_cdv = 1; s_priv = 2'd1; s_trans = 1;
    send(2'd0, 27'h10, '0, '0);
    wait_resp("req036_fault", 4'b0000, lat);
    check("req036_latency", lat, 1);
    check("req036_data", last_data, d036);

    // poison the fetch in S2: no icache request, no response
    send(2'd0, 27'h10, '0, '0);
    s_poison = 1; step(); s_poison = 0;
    cpv_seen = obs_cpv; rv_seen = obs_rv;
    for (int k = 0; k < 3; k++) begin
      step();
      cpv_seen += obs_cpv; rv_seen += obs_rv;
    end
    check("req040_no_cpv", cpv_seen, 0);
    check("req040_no_resp", rv_seen, 0);
    send(2'd2, '0, '0, '0);
    send(2'd0, 27'h10, '0, '0);
    wait_resp("req040_refetch", 4'b1000, lat);

    // empty TLB, translation on: itlb miss, zero data
    send(2'd0, 27'h20, '0, '0);
    wait_resp("req037_fault", 4'b1000, lat);
    check("req037_data", last_data, 0);

    // 9 distinct fills into 8 entries: first entry is evicted
    send(2'd2, '0, '0, '0);
    s_priv = 2'd3;
    for (int i = 0; i < 9; i++) send(2'd1, vw'(32'h100 + i), pw'(32'h80100 + i), 2'b01);
    for (int i = 0; i < 9; i++) begin
      send(2'd0, vw'(32'h100 + i), '0, '0);
      wait_resp($sformatf("req038_fetch%0d", i), (i == 0) ? 4'b1000 : 4'b0000, lat);
    end

    // back-pressure: only two fetches fit while responses are held
    s_rready = 0; s_v = 1; s_op = 2'd0; s_vtag = 27'h101;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      acc += obs_ready;
    end
    check("req039_accepted", acc, 2);
    s_v = 0; s_rready = 1;
    repeat (4) step();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      int r, pv;
      s_v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 19);
      s_op = (r < 12) ? 2'd0 : (r < 18) ? 2'd1 : (r == 18) ? 2'd2 : 2'd3;
      s_vtag = vw'($urandom_range(0, 11));
      s_ptag = ($urandom_range(0, 4) == 0) ? pw'($urandom_range(0, 'h7ffff))
                                           : dram_base + pw'($urandom_range(0, 255));
      s_attr = 2'($urandom);
      s_trans = ($urandom_range(0, 7) != 0);
      pv = $urandom_range(0, 2);
      s_priv = (pv == 2) ? 2'd3 : 2'(pv);
      s_poison = ($urandom_range(0, 9) == 0);
      s_cdata = {$urandom, $urandom};
      s_cdv = ($urandom_range(0, 4) != 0);
      s_rready = ($urandom_range(0, 9) < 7);
      step();
    end
    s_v = 0; s_poison = 0; s_rready = 1;
    repeat (5) step();
    check("drain_empty", bus.resp_v_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
